// File: rtl/sigmoid_scheduler.sv
// Round-robin scheduler sharing one sigmoid unit among NUM_REQ neuron accumulators.
// Ports: clk, rst_n, start, req_valid/req_data/req_ready, out_valid/out_ready/out_data/out_id, busy, done.

// Sigmoid approximation: y = floor(16 * sigmoid(x)), x signed fixed point with QN fraction bits.
// Ports: x (accumulator word), y (0..15).
module sigmoid #(
  parameter int N  = 2,
  parameter int QM = 12,
  parameter int QN = 20,
  localparam int W = N + QM + QN
) (
  input  logic [W-1:0] x,
  output logic [7:0]   y
);

  // |ln(k/(16-k))| for k = 8+d, in Q20, floored; y steps at +/- these points.
  function automatic longint th(input int d);
    longint m;
    case (d)
      1:       m = 64'sd263522;
      2:       m = 64'sd535639;
      3:       m = 64'sd826757;
      4:       m = 64'sd1151978;
      5:       m = 64'sd1537565;
      6:       m = 64'sd2040434;
      7:       m = 64'sd2839596;
      default: m = 64'sd0;
    endcase
    return (m <<< QN) >>> 20;
  endfunction

  logic signed [63:0] xs;

  always_comb begin
    xs = {{(64-W){x[W-1]}}, x};
    y  = 8'(xs >= 64'sd0);
    for (int d = 1; d <= 7; d++) begin
      y = y + 8'(xs > th(d));
      y = y + 8'(xs >= -th(d));
    end
  end

endmodule

module sigmoid_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int N       = 2,
  parameter int QM      = 12,
  parameter int QN      = 20,
  localparam int W      = N + QM + QN,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic [IDW-1:0]       out_id,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [IDW:0] NR = (IDW+1)'(NUM_REQ);

  state_t             state, nxt;
  logic [NUM_REQ-1:0] served;
  logic [IDW-1:0]     rr_ptr;
  logic               s1_v;
  logic [W-1:0]       s1_d;
  logic [IDW-1:0]     s1_id;
  logic [7:0]         sig_y;

  logic               found;
  logic [IDW:0]       idx;
  logic               gnt_v;
  logic [IDW-1:0]     gnt_id;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               s2_load;
  logic               s1_free;
  logic               all_srv;

  sigmoid #(.N(N), .QM(QM), .QN(QN)) u_sig (
    .x (s1_d),
    .y (sig_y)
  );

  assign s2_load = !out_valid || out_ready;
  assign s1_free = !s1_v || s2_load;

  // Search from rr_ptr upward, wrapping, for the first unserved valid requester.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    gnt_id = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(j);
      if (idx >= NR) idx = idx - NR;
      if (!found && req_valid[idx[IDW-1:0]]
          && !served[idx[IDW-1:0]]) begin
        found  = 1'b1;
        gnt_id = idx[IDW-1:0];
      end
    end
    gnt_v   = found && (state == RUN) && s1_free;
    gnt_oh  = gnt_v ? (NUM_REQ'(1) << gnt_id) : '0;
    all_srv = (served | gnt_oh) == {NUM_REQ{1'b1}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (gnt_v && all_srv) nxt = DRAIN;
      // Leave on the edge that completes the last handshake.
      DRAIN:   if (!s1_v && s2_load) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = gnt_oh;
    busy      = state != IDLE;
    done      = state == DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      served    <= '0;
      rr_ptr    <= '0;
      s1_v      <= 1'b0;
      s1_d      <= '0;
      s1_id     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      if (s2_load) begin
        out_valid <= s1_v;
        if (s1_v) begin
          out_data <= sig_y;
          out_id   <= s1_id;
        end
      end
      if (gnt_v) begin
        s1_v           <= 1'b1;
        s1_d           <= req_data[int'(gnt_id)*W +: W];
        s1_id          <= gnt_id;
        served[gnt_id] <= 1'b1;
        rr_ptr <= (gnt_id == IDW'(NUM_REQ-1)) ? '0
                : gnt_id + IDW'(1);
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end
      if (state == IDLE && start) begin
        served <= '0;
        rr_ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_scheduler.sv
// Self-checking bench for sigmoid_scheduler: directed scenarios plus
// randomized layers against a queue-based reference model.
module tb_sigmoid_scheduler;

  localparam int NR = 4;
  localparam int W  = 34;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*W-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic [1:0]    out_id;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;
  longint dv[NR];

  typedef struct {
    int id;
    int data;
    int age;
  } item_t;

  always #5 clk = ~clk;

  sigmoid_scheduler #(.NUM_REQ(NR), .N(2), .QM(12), .QN(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy),
    .done      (done)
  );

  function automatic int sig_ref(input longint x);
    real r;
    real s;
    int  v;
    r = real'(x) / 1048576.0;
    s = 16.0 / (1.0 + $exp(-r));
    v = int'($floor(s));
    if (v > 15) v = 15;
    if (v < 0) v = 0;
    return v;
  endfunction

  task automatic set_data(input int i, input longint v);
    dv[i] = v;
    req_data[i*W +: W] = W'(v);
  endtask

  task automatic rand_data();
    for (int i = 0; i < NR; i++)
      set_data(i, longint'($urandom_range(12582912, 0)) - 64'sd6291456);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    next_cyc();
    rst_n = 1'b1;
  endtask

  task automatic start_layer();
    start = 1'b1;
    next_cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    next_cyc();
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    tests++;
    if (req_ready !== 4'b0) begin
      fails++;
      $display("FAIL reset_req_ready got %b want 0000", req_ready);
    end
    tests++;
    if (out_data !== 8'd0 || out_id !== 2'd0) begin
      fails++;
      $display("FAIL reset_out got %0d/%0d want 0/0", out_data, out_id);
    end
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy_done got %b%b want 00", busy, done);
    end
    rst_n = 1'b1;
    next_cyc();
    #1;
    tests++;
    if (busy !== 1'b0 || req_ready !== 4'b0) begin
      fails++;
      $display("FAIL idle_no_start got busy=%b rr=%b want 0/0000",
               busy, req_ready);
    end
  endtask

  task automatic test_single();
    int bad;
    do_reset();
    start_layer();
    req_valid = 4'b0001;
    set_data(0, 0);
    out_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL single_grant got %b want 0001", req_ready);
    end
    next_cyc();
    #1;
    tests++;
    if (req_ready !== 4'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_k1 got rr=%b ov=%b want 0000/0",
               req_ready, out_valid);
    end
    next_cyc();
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'd8 || out_id !== 2'd0) begin
      fails++;
      $display("FAIL single_out got v=%b d=%0d id=%0d want 1/8/0",
               out_valid, out_data, out_id);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      next_cyc();
      #1;
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL single_stays_run got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_full_layer();
    int ed[4] = '{15, 0, 8, 11};
    logic [3:0] eg;
    do_reset();
    start_layer();
    set_data(0, 64'sd10485760);
    set_data(1, -64'sd10485760);
    set_data(2, 0);
    set_data(3, 64'sd1048576);
    req_valid = '1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      eg = (c < 4) ? 4'(1 << c) : 4'b0;
      tests++;
      if (req_ready !== eg) begin
        fails++;
        $display("FAIL full_grant c%0d got %b want %b", c, req_ready, eg);
      end
      tests++;
      if (out_valid !== (c >= 2 && c <= 5)) begin
        fails++;
        $display("FAIL full_ov c%0d got %b", c, out_valid);
      end
      if (c >= 2 && c <= 5) begin
        tests++;
        if (out_data !== 8'(ed[c-2]) || out_id !== 2'(c-2)) begin
          fails++;
          $display("FAIL full_out c%0d got %0d/%0d want %0d/%0d",
                   c, out_data, out_id, ed[c-2], c-2);
        end
      end
      tests++;
      if (done !== (c == 6) || busy !== (c < 7)) begin
        fails++;
        $display("FAIL full_done_busy c%0d got %b%b", c, done, busy);
      end
      next_cyc();
    end
  endtask

  task automatic test_wrap_gaps();
    int order[3] = '{2, 3, 0};
    int k;
    int saw;
    logic [3:0] eg;
    do_reset();
    start_layer();
    rand_data();
    req_valid = 4'b1100;
    out_ready = 1'b1;
    k = 0;
    saw = 0;
    for (int c = 0; c < 13; c++) begin
      if (c == 2) req_valid = 4'b1101;
      #1;
      eg = (c == 0) ? 4'b0100 : (c == 1) ? 4'b1000
         : (c == 2) ? 4'b0001 : 4'b0000;
      tests++;
      if (req_ready !== eg) begin
        fails++;
        $display("FAIL wrap_grant c%0d got %b want %b", c, req_ready, eg);
      end
      if (out_valid === 1'b1 && k < 3) begin
        tests++;
        if (out_id !== 2'(order[k])
            || out_data !== 8'(sig_ref(dv[order[k]]))) begin
          fails++;
          $display("FAIL wrap_out got %0d/%0d want %0d/%0d", out_id,
                   out_data, order[k], sig_ref(dv[order[k]]));
        end
        k++;
      end
      if (done === 1'b1) saw = 1;
      next_cyc();
    end
    tests++;
    if (k != 3 || saw != 0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL wrap_end got n=%0d done=%0d busy=%b want 3/0/1",
               k, saw, busy);
    end
  endtask

  task automatic test_backpressure();
    int ng;
    int k;
    int saw;
    int held;
    logic [7:0] hd;
    logic [1:0] hid;
    do_reset();
    start_layer();
    rand_data();
    req_valid = '1;
    out_ready = 1'b0;
    ng = 0;
    held = 0;
    hd = '0;
    hid = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (req_ready != 4'b0) ng++;
      if (out_valid === 1'b1) begin
        if (held == 0) begin
          hd = out_data;
          hid = out_id;
          held = 1;
          tests++;
          if (hid !== 2'd0 || hd !== 8'(sig_ref(dv[0]))) begin
            fails++;
            $display("FAIL bp_first got %0d/%0d want 0/%0d",
                     hid, hd, sig_ref(dv[0]));
          end
        end else begin
          tests++;
          if (out_data !== hd || out_id !== hid) begin
            fails++;
            $display("FAIL bp_stable got %0d/%0d want %0d/%0d",
                     out_id, out_data, hid, hd);
          end
        end
      end
      next_cyc();
    end
    tests++;
    if (ng != 2) begin
      fails++;
      $display("FAIL bp_grants got %0d want 2", ng);
    end
    out_ready = 1'b1;
    k = 0;
    saw = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        if (k < 4) begin
          tests++;
          if (out_id !== 2'(k) || out_data !== 8'(sig_ref(dv[k]))) begin
            fails++;
            $display("FAIL bp_out got %0d/%0d want %0d/%0d",
                     out_id, out_data, k, sig_ref(dv[k]));
          end
        end
        k++;
      end
      if (done === 1'b1) saw = 1;
      next_cyc();
    end
    tests++;
    if (k != 4 || saw != 1) begin
      fails++;
      $display("FAIL bp_total got n=%0d done=%0d want 4/1", k, saw);
    end
  endtask

  task automatic test_restart();
    int cnt[4];
    int saw;
    do_reset();
    start_layer();
    rand_data();
    req_valid = '1;
    out_ready = 1'b1;
    cnt = '{0, 0, 0, 0};
    saw = 0;
    for (int c = 0; c < 15; c++) begin
      start = (c == 2);
      #1;
      for (int i = 0; i < NR; i++) if (req_ready[i]) cnt[i]++;
      if (done === 1'b1) saw = 1;
      next_cyc();
    end
    start = 1'b0;
    for (int i = 0; i < NR; i++) begin
      tests++;
      if (cnt[i] != 1) begin
        fails++;
        $display("FAIL restart_cnt n%0d got %0d want 1", i, cnt[i]);
      end
    end
    tests++;
    if (saw != 1) begin
      fails++;
      $display("FAIL restart_done got %0d want 1", saw);
    end
    start_layer();
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++;
      if (req_ready !== 4'(1 << c)) begin
        fails++;
        $display("FAIL restart_regrant c%0d got %b want %b",
                 c, req_ready, 4'(1 << c));
      end
      next_cyc();
    end
  endtask

  task automatic test_mid_reset();
    int saw;
    do_reset();
    start_layer();
    rand_data();
    req_valid = '1;
    out_ready = 1'b0;
    next_cyc();
    next_cyc();
    #1;
    tests++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mrst_pre got ov=%b busy=%b want 1/1", out_valid, busy);
    end
    rst_n = 1'b0;
    next_cyc();
    #1;
    tests++;
    if (out_valid !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mrst_post got ov=%b rr=%b busy=%b want 0/0000/0",
               out_valid, req_ready, busy);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    saw = 0;
    for (int c = 0; c < 6; c++) begin
      next_cyc();
      #1;
      if (done === 1'b1 || busy === 1'b1 || out_valid === 1'b1) saw++;
    end
    tests++;
    if (saw != 0) begin
      fails++;
      $display("FAIL mrst_quiet got %0d active cycles want 0", saw);
    end
  endtask

  task automatic test_random();
    item_t q[$];
    int ms;
    int mptr;
    logic [3:0] msv;
    int eg_v;
    int eg_id;
    int idx;
    int ev;
    int cyc;
    int fin;
    logic [3:0] exp_rr;
    do_reset();
    for (int l = 0; l < 8; l++) begin
      q.delete();
      ms = 0;
      mptr = 0;
      msv = '0;
      cyc = 0;
      fin = 0;
      while (!fin && cyc < 300) begin
        start = (cyc == 0);
        req_valid = 4'($urandom);
        out_ready = ($urandom_range(3, 0) != 0);
        rand_data();
        #1;
        eg_v = 0;
        eg_id = 0;
        if (ms == 1)
          for (int j = 0; j < NR; j++) begin
            idx = (mptr + j) % NR;
            if (eg_v == 0 && req_valid[idx] && !msv[idx]) begin
              eg_v = 1;
              eg_id = idx;
            end
          end
        if (!(q.size() < 2 || out_ready)) eg_v = 0;
        exp_rr = (eg_v != 0) ? 4'(1 << eg_id) : 4'b0;
        tests++;
        if (req_ready !== exp_rr) begin
          fails++;
          $display("FAIL rnd_grant L%0d c%0d got %b want %b",
                   l, cyc, req_ready, exp_rr);
        end
        ev = (q.size() > 0) ? ((q[0].age >= 1) ? 1 : 0) : 0;
        tests++;
        if (out_valid !== 1'(ev)) begin
          fails++;
          $display("FAIL rnd_ov L%0d c%0d got %b want %0d",
                   l, cyc, out_valid, ev);
        end
        if (ev != 0 && out_valid === 1'b1) begin
          tests++;
          if (out_id !== 2'(q[0].id) || out_data !== 8'(q[0].data)) begin
            fails++;
            $display("FAIL rnd_out L%0d c%0d got %0d/%0d want %0d/%0d",
                     l, cyc, out_id, out_data, q[0].id, q[0].data);
          end
        end
        tests++;
        if (done !== (ms == 3) || busy !== (ms != 0)) begin
          fails++;
          $display("FAIL rnd_state L%0d c%0d got done=%b busy=%b ms=%0d",
                   l, cyc, done, busy, ms);
        end
        if (ev != 0 && out_ready) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (eg_v != 0) begin
          q.push_back('{eg_id, sig_ref(dv[eg_id]), 0});
          msv[eg_id] = 1'b1;
          mptr = (eg_id + 1) % NR;
        end
        case (ms)
          0: if (start) begin ms = 1; msv = '0; mptr = 0; end
          1: if (eg_v != 0 && msv == 4'hf) ms = 2;
          2: if (q.size() == 0) ms = 3;
          default: begin ms = 0; fin = 1; end
        endcase
        cyc++;
        next_cyc();
      end
      start = 1'b0;
      if (!fin) begin
        tests++;
        fails++;
        $display("FAIL rnd_timeout L%0d got no completion in 300 cycles", l);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_layer();
    test_wrap_gaps();
    test_backpressure();
    test_restart();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/sigmoid_scheduler.md
Name: sigmoid_scheduler

Overview:
Shares one Sigmoid activation unit among NUM_REQ neuron accumulators in a layer. Each accumulator is served exactly once per layer. Requesters are granted in round-robin order. Each accepted accumulator value passes through a 2-stage pipeline around an internal Sigmoid instance, and the 8-bit result leaves on a valid/ready stream tagged with the requester index. The block sits between the neuron MAC array and the layer output buffer, and pulses done when every neuron's activation has been delivered.

Parameters:
NUM_REQ, 4, number of requesting neurons; must be 1 or more.
N, 2, integer guard bits of the accumulator word; passed to Sigmoid.
QM, 12, integer bits of the accumulator word; passed to Sigmoid.
QN, 20, fractional bits of the accumulator word; passed to Sigmoid.
(Derived: W = N+QM+QN; IDW = max(1, clog2(NUM_REQ)).)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset; synchronous, active-low
start  input  1  one-cycle pulse that begins a layer; honoured only in IDLE
req_valid  input  NUM_REQ  per-neuron "accumulator value ready"
req_data  input  NUM_REQ*W  packed accumulator values; neuron i occupies bits [i*W +: W]
req_ready  output  NUM_REQ  one-hot grant/accept
out_valid  output  1  activation result valid
out_ready  input  1  downstream accepts the result
out_data  output  8  sigmoid result
out_id  output  IDW  index of the neuron that produced out_data
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse after the last result of the layer is accepted

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; rr_ptr = 0; served mask = 0; both pipeline stages empty.
  - out_valid = 0, out_data = 0, out_id = 0, done = 0, busy = 0; req_ready = 0.
  - Reset mid-layer discards all in-flight data. No done pulse is issued.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: req_ready = 0. On start, clear served mask, set rr_ptr = 0, go to RUN.
  - RUN: arbitration is active. When the served mask is all ones, go to DRAIN. The transition happens on the same edge that accepts the last request.
  - DRAIN: no grants. When both stages are empty (last out handshake complete), go to DONE.
  - DONE: done = 1 for exactly one cycle, then go to IDLE.
  - start is ignored outside IDLE.
- Arbitration (RUN only):
  - Candidate i is eligible when req_valid[i] && !served[i].
  - Grant goes to the first eligible index searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Grant is issued only if stage1 can load, i.e. stage1 is empty or stage1 advances this cycle.
  - req_ready is combinational and one-hot. It is 0 when there is no grant.
  - On the accept edge: stage1 <= {req_data slice, i}; served[i] <= 1; rr_ptr <= (i+1) mod NUM_REQ.
  - A requester that drops req_valid before being granted loses nothing: it stays unserved.
- Pipeline:
  - Stage1 registers the accumulator word and its id.
  - The Sigmoid input is driven combinationally from stage1 data.
  - Stage2 registers the Sigmoid output as out_data, stage1 id as out_id, and sets out_valid.
  - Stage2 loads when it is empty or out_ready is high. Stage1 advances whenever stage2 loads.
  - Latency: a request accepted at edge k produces out_valid after edge k+1. Full throughput is 1 per cycle when out_ready is held high.
- Backpressure:
  - While out_valid && !out_ready, out_data and out_id hold stable.
  - Stage1 holds, and no new grant is issued if stage1 is full.
- Simultaneous events:
  - An accept into stage1 and a stage1→stage2 move on the same edge is legal.
  - An out handshake and a stage2 reload on the same edge is legal; out_valid stays 1.
- NUM_REQ = 1: rr_ptr stays 0, out_id = 0, and the layer completes after one result.

Test Plan:
- Single neuron: reset, start, req_valid = 4'b0001, req_data[0] = 0, out_ready = 1 -> req_ready = 4'b0001 for one cycle; out_valid 2 edges later with out_data = 8 (16·0.5) and out_id = 0; the layer then stays in RUN until the other three neurons are served.
- Full layer, round-robin: all req_valid high from start, data = {+10.0, −10.0, 0, +1.0} scaled by 2^20 -> grants in order 0,1,2,3 on consecutive cycles; outputs 15, 0, 8, Sigmoid(1.0); done pulses one cycle after the 4th out handshake; busy is low the cycle after done.
- Wrap and gaps: only neurons 2 and 3 are valid first, then neuron 0 two cycles later -> grant order 2,3,0 (search wraps from rr_ptr = 0 after 3); neuron 1 is never valid -> FSM remains in RUN and done is never asserted.
- Backpressure: out_ready held low for 5 cycles with all requests valid -> exactly 2 grants occur; out_data and out_id stay stable while stalled; on release the remaining results stream with no loss or duplication.
- Restart rules: start pulsed during RUN -> ignored; no re-grant to already-served neurons. After done, a new start re-serves all neurons.
- Mid-layer reset: rst_n low for 1 cycle with 2 results in flight -> out_valid = 0, req_ready = 0, busy = 0 next cycle; no done pulse.
